// File: rtl/sram_bank_sched.sv
// sram_bank_sched
// Per-bank access scheduler in front of the SRAM block array. NUM_REQ
// command lanes share NUM_BANK single-port banks. Each bank issues at most
// one command per cycle and picks its winner round-robin. Each bank also
// enforces an occupancy window (BUSY_CYC) and an extra read/write
// turnaround gap (TURN).
//
// Ports:
//   clk            core clock
//   rst_n          asynchronous reset, active HIGH (1 = reset)
//   sched_en       global grant enable
//   req_vld        per-lane request valid
//   req_rdy        per-lane grant (combinational); handshake = vld & rdy
//   req_is_wr      per-lane direction, 1 = write
//   req_bank       per-lane target bank, flattened, lane 0 in LSBs
//   req_addr       per-lane in-bank address, flattened
//   bank_cmd_vld   registered one-cycle issue strobe per bank
//   bank_cmd_wr    direction of the last issued command per bank
//   bank_cmd_addr  address of the last issued command per bank
//   bank_cmd_src   winning lane index of the last issue per bank
//   bank_busy      1 while the bank's busy counter is non-zero
module sram_bank_sched #(
  parameter int NUM_REQ  = 8,
  parameter int NUM_BANK = 8,
  parameter int ADDR_W   = 10,
  parameter int BUSY_CYC = 2,
  parameter int TURN     = 1,
  localparam int REQ_W   = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1,
  localparam int BANK_W  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int CNT_W   = (BUSY_CYC + TURN > 1) ? $clog2(BUSY_CYC + TURN) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sched_en,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ-1:0]         req_is_wr,
  input  logic [NUM_REQ*BANK_W-1:0]  req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_BANK-1:0]        bank_cmd_vld,
  output logic [NUM_BANK-1:0]        bank_cmd_wr,
  output logic [NUM_BANK*ADDR_W-1:0] bank_cmd_addr,
  output logic [NUM_BANK*REQ_W-1:0]  bank_cmd_src,
  output logic [NUM_BANK-1:0]        bank_busy
);

  logic [NUM_BANK-1:0][CNT_W-1:0]  busy_cnt;
  logic [NUM_BANK-1:0][CNT_W-1:0]  turn_cnt;
  logic [NUM_BANK-1:0]             last_wr;
  logic [NUM_BANK-1:0][REQ_W-1:0]  rr_ptr;

  logic [NUM_REQ-1:0][BANK_W-1:0]  lane_bank;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  lane_addr;

  logic [NUM_BANK-1:0]             win_vld;
  logic [NUM_BANK-1:0][REQ_W-1:0]  win_idx;
  logic [REQ_W-1:0]                scan_idx;

  // Unpack the flattened per-lane fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_bank[i] = req_bank[i*BANK_W +: BANK_W];
      lane_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin scan per bank, starting at rr_ptr. A lane that wants the
  // opposite direction while turn_cnt is still running is skipped. It does
  // not stop the scan, so same-direction lanes behind it can still win.
  // A lane names exactly one bank, so it can win at most once per cycle.
  always_comb begin
    win_vld  = '0;
    win_idx  = '0;
    req_rdy  = '0;
    scan_idx = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = rr_ptr[b] + REQ_W'(k);
        if (!win_vld[b] && sched_en && req_vld[scan_idx] &&
            (lane_bank[scan_idx] == BANK_W'(b)) && (busy_cnt[b] == '0) &&
            ((req_is_wr[scan_idx] == last_wr[b]) || (turn_cnt[b] == '0))) begin
          win_vld[b] = 1'b1;
          win_idx[b] = scan_idx;
        end
      end
      if (win_vld[b]) begin
        req_rdy[win_idx[b]] = 1'b1;
      end
    end
    if (rst_n) begin
      req_rdy = '0;
    end
  end

  // Issue registers and per-bank timing state. When a bank grants, it loads
  // its counters. Otherwise the counters run down to zero, even while
  // sched_en is low. The command fields hold their last value between issues.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bank_cmd_vld  <= '0;
      bank_cmd_wr   <= '0;
      bank_cmd_addr <= '0;
      bank_cmd_src  <= '0;
      busy_cnt      <= '0;
      turn_cnt      <= '0;
      last_wr       <= '0;
      rr_ptr        <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        bank_cmd_vld[b] <= win_vld[b];
        if (win_vld[b]) begin
          bank_cmd_wr[b]                    <= req_is_wr[win_idx[b]];
          bank_cmd_addr[b*ADDR_W +: ADDR_W] <= lane_addr[win_idx[b]];
          bank_cmd_src[b*REQ_W +: REQ_W]    <= win_idx[b];
          busy_cnt[b]                       <= CNT_W'(BUSY_CYC - 1);
          turn_cnt[b]                       <= CNT_W'(BUSY_CYC - 1 + TURN);
          last_wr[b]                        <= req_is_wr[win_idx[b]];
          rr_ptr[b]                         <= win_idx[b] + REQ_W'(1);
        end else begin
          if (busy_cnt[b] != '0) begin
            busy_cnt[b] <= busy_cnt[b] - CNT_W'(1);
          end
          if (turn_cnt[b] != '0) begin
            turn_cnt[b] <= turn_cnt[b] - CNT_W'(1);
          end
        end
      end
    end
  end

  // The busy flag is decoded straight from the busy counter register.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_busy[b] = (busy_cnt[b] != '0);
    end
  end

endmodule

// File: tb/tb_sram_bank_sched.sv
// tb_sram_bank_sched
// Directed bench for sram_bank_sched with the default parameters
// (8 lanes, 8 banks, 10-bit address, BUSY_CYC=2, TURN=1).
// Inputs change 1 time unit after a rising edge. req_rdy is sampled on the
// falling edge. Registered outputs are sampled 1 time unit after the
// rising edge.
module tb_sram_bank_sched;

  localparam int NREQ = 8;
  localparam int NBNK = 8;
  localparam int AW   = 10;

  logic             clk;
  logic             rst_n;
  logic             sched_en;
  logic [NREQ-1:0]  req_vld;
  logic [NREQ-1:0]  req_rdy;
  logic [NREQ-1:0]  req_is_wr;
  logic [NREQ*3-1:0]  req_bank;
  logic [NREQ*AW-1:0] req_addr;
  logic [NBNK-1:0]  bank_cmd_vld;
  logic [NBNK-1:0]  bank_cmd_wr;
  logic [NBNK*AW-1:0] bank_cmd_addr;
  logic [NBNK*3-1:0]  bank_cmd_src;
  logic [NBNK-1:0]  bank_busy;

  int checks;
  int errors;

  sram_bank_sched #(
    .NUM_REQ(NREQ), .NUM_BANK(NBNK), .ADDR_W(AW), .BUSY_CYC(2), .TURN(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sched_en(sched_en),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_is_wr(req_is_wr),
    .req_bank(req_bank),
    .req_addr(req_addr),
    .bank_cmd_vld(bank_cmd_vld),
    .bank_cmd_wr(bank_cmd_wr),
    .bank_cmd_addr(bank_cmd_addr),
    .bank_cmd_src(bank_cmd_src),
    .bank_busy(bank_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one lane's request fields.
  task automatic applyStimulus(input int lane, input bit vld, input bit wr,
                               input int bank, input int addr);
    req_vld[lane]             = vld;
    req_is_wr[lane]           = wr;
    req_bank[lane*3 +: 3]     = 3'(bank);
    req_addr[lane*AW +: AW]   = AW'(addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src_of(input int b);
    return 32'(bank_cmd_src[b*3 +: 3]);
  endfunction

  function automatic logic [31:0] addr_of(input int b);
    return 32'(bank_cmd_addr[b*AW +: AW]);
  endfunction

  // Hold reset for one cycle and check the reset view of every output.
  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rdy", 32'(req_rdy), 32'h0);
    checkOutput("rst_vld", 32'(bank_cmd_vld), 32'h0);
    checkOutput("rst_busy", 32'(bank_busy), 32'h0);
    checkOutput("rst_wr", 32'(bank_cmd_wr), 32'h0);
    checkOutput("rst_src", 32'(bank_cmd_src), 32'h0);
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    int order [3];
    logic [7:0] exp_rdy;
    int lane;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    sched_en  = 1'b1;
    req_vld   = '0;
    req_is_wr = '0;
    req_bank  = '0;
    req_addr  = '0;
    tick();

    // One lane issues three reads to bank 2, spaced by BUSY_CYC.
    do_reset();
    applyStimulus(3, 1, 0, 2, 'h55);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("t1_rdy", 32'(req_rdy),
                  ((c % 2 == 0) && (c < 5)) ? 32'h08 : 32'h00);
      tick();
      if (c == 4) applyStimulus(3, 0, 0, 2, 'h55);
      checkOutput("t1_vld", 32'(bank_cmd_vld[2]), 32'((c % 2 == 0) && (c < 5)));
      checkOutput("t1_busy", 32'(bank_busy[2]), 32'((c % 2 == 0) && (c < 5)));
    end
    checkOutput("t1_src", src_of(2), 32'd3);
    checkOutput("t1_addr", addr_of(2), 32'h55);
    checkOutput("t1_wr", 32'(bank_cmd_wr[2]), 32'h0);

    // A write then a read to bank 5: the read has to wait the turnaround.
    do_reset();
    applyStimulus(0, 1, 1, 5, 'h1A1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("t2_rdy", 32'(req_rdy), ((c == 0) || (c == 3)) ? 32'h01 : 32'h00);
      tick();
      if (c == 0) applyStimulus(0, 1, 0, 5, 'h0F0);
      if (c == 3) applyStimulus(0, 0, 0, 5, 'h0F0);
      checkOutput("t2_vld", 32'(bank_cmd_vld[5]), 32'((c == 0) || (c == 3)));
      checkOutput("t2_wr", 32'(bank_cmd_wr[5]), 32'(c != 3));
      checkOutput("t2_addr", addr_of(5), (c == 3) ? 32'h0F0 : 32'h1A1);
    end

    // Lanes 0, 1 and 7 keep reading bank 0. The pointer wraps from 7 to 0.
    do_reset();
    order[0] = 0;
    order[1] = 1;
    order[2] = 7;
    applyStimulus(0, 1, 0, 0, 'h010);
    applyStimulus(1, 1, 0, 0, 'h011);
    applyStimulus(7, 1, 0, 0, 'h017);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rdy = (c % 2 == 0) ? (8'h01 << order[(c / 2) % 3]) : 8'h00;
      checkOutput("t3_rdy", 32'(req_rdy), 32'(exp_rdy));
      tick();
      checkOutput("t3_vld", 32'(bank_cmd_vld[0]), 32'(c % 2 == 0));
      if (c % 2 == 0) begin
        checkOutput("t3_src", src_of(0), 32'(order[(c / 2) % 3]));
        checkOutput("t3_addr", addr_of(0), 32'h010 + 32'(order[(c / 2) % 3]));
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(7, 0, 0, 0, 0);

    // Every lane targets a different bank, so all eight are granted at once.
    do_reset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1, i % 2, i ^ 3, 'h100 + i * 3);
    @(negedge clk);
    checkOutput("t4_rdy", 32'(req_rdy), 32'hFF);
    tick();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 0, 0, 0, 0);
    checkOutput("t4_vld", 32'(bank_cmd_vld), 32'hFF);
    for (int b = 0; b < NBNK; b++) begin
      lane = b ^ 3;
      checkOutput("t4_src", src_of(b), 32'(lane));
      checkOutput("t4_addr", addr_of(b), 32'h100 + 32'(lane * 3));
      checkOutput("t4_wr", 32'(bank_cmd_wr[b]), 32'(lane % 2));
    end

    // sched_en is low for four cycles while a request stays pending.
    do_reset();
    applyStimulus(2, 1, 0, 1, 'h33);
    @(negedge clk);
    checkOutput("t5_rdy0", 32'(req_rdy), 32'h04);
    tick();
    sched_en = 1'b0;
    checkOutput("t5_busy1", 32'(bank_busy[1]), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("t5_rdy_off", 32'(req_rdy), 32'h00);
      tick();
      if (c == 4) sched_en = 1'b1;
      checkOutput("t5_busy_off", 32'(bank_busy[1]), 32'h0);
      checkOutput("t5_vld_off", 32'(bank_cmd_vld[1]), 32'h0);
    end
    @(negedge clk);
    checkOutput("t5_rdy_on", 32'(req_rdy), 32'h04);
    tick();
    applyStimulus(2, 0, 0, 1, 'h33);
    checkOutput("t5_vld_on", 32'(bank_cmd_vld[1]), 32'h1);
    checkOutput("t5_src", src_of(1), 32'd2);

    // Pulse reset for one cycle while traffic is flowing. Afterwards the
    // round-robin pointer starts again from lane 0.
    do_reset();
    applyStimulus(0, 1, 0, 0, 'h020);
    applyStimulus(1, 1, 0, 0, 'h021);
    applyStimulus(7, 1, 0, 0, 'h027);
    @(negedge clk);
    checkOutput("t6_rdy_pre", 32'(req_rdy), 32'h01);
    tick();
    checkOutput("t6_vld_pre", 32'(bank_cmd_vld[0]), 32'h1);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_vld_rst", 32'(bank_cmd_vld), 32'h0);
    checkOutput("t6_busy_rst", 32'(bank_busy), 32'h0);
    checkOutput("t6_addr_rst", addr_of(0), 32'h0);
    checkOutput("t6_rdy_rst", 32'(req_rdy), 32'h0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rdy_post", 32'(req_rdy), 32'h01);
    tick();
    checkOutput("t6_src_post", src_of(0), 32'd0);
    checkOutput("t6_vld_post", 32'(bank_cmd_vld[0]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
